timer_device: RTL and testbench

Memory-mapped countdown timer that answers the processor's data-memory bus (`m_data_addr` / `m_data_wdata` / `m_data_byteen` / `m_data_rdata`) and drives one `HWInt` line back into the core. It is the responder for CPU loads and stores that hit its address window. It counts down from a programmable preset and raises an interrupt in either one-shot or auto-reload mode. It sits beside data memory behind the system address decode.

---
 rtl/timer_device_pkg.sv | 42 ++++
 rtl/timer_device.sv | 126 ++++++++++++
 tb/tb_timer_device.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_device_pkg.sv
// Shared constants for the memory-mapped countdown timer.
// Holds register offsets, CTRL bit positions, MODE codes, FSM state
// encodings, the default window base and the byte-lane write merge helper.
package timer_device_pkg;

  localparam logic [31:0] DefaultBaseAddr = 32'h0000_7F00;

  // Word offsets within the 16-byte window (addr[3:2])
  localparam logic [1:0] OffCtrl   = 2'd0;
  localparam logic [1:0] OffPreset = 2'd1;
  localparam logic [1:0] OffCount  = 2'd2;

  // CTRL bit positions
  localparam int unsigned CtrlEnBit  = 0;
  localparam int unsigned CtrlModeLo = 1;
  localparam int unsigned CtrlModeHi = 2;
  localparam int unsigned CtrlImBit  = 3;

  // MODE codes; 2'b1x is treated as one-shot
  localparam logic [1:0] ModeOneShot = 2'b00;
  localparam logic [1:0] ModeReload  = 2'b01;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCnt  = 2'd2,
    StInt  = 2'd3
  } tmr_state_e;

  // Replace each byte lane whose enable is set with the matching write byte.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wr_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wr_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_device.sv
// Memory-mapped countdown timer on the CPU data-memory bus.
// Counts down from PRESET and raises an interrupt in one-shot or
// auto-reload mode.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, clears all state
//   addr   - bus byte address; window selected by addr[31:4]
//   byteen - write byte enables, nonzero means a write
//   wdata  - write data
//   rdata  - combinational read data, 0 when not selected
//   irq    - interrupt request (pending & IM)
module timer_device
  import timer_device_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [3:0]  ctrl_q, ctrl_d, ctrl_fsm, ctrl_bus;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  tmr_state_e  state_q, state_d;

  logic       sel, wr_en, ctrl_wr, preset_wr;
  logic [1:0] off;
  logic       en, im;
  logic [1:0] mode;

  // Byte-offset bits are don't-care for word registers
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
  assign off       = addr[3:2];
  assign wr_en     = sel && (byteen != 4'b0000);
  assign ctrl_wr   = wr_en && (off == OffCtrl);
  assign preset_wr = wr_en && (off == OffPreset);

  assign en   = ctrl_q[CtrlEnBit];
  assign im   = ctrl_q[CtrlImBit];
  assign mode = ctrl_q[CtrlModeHi:CtrlModeLo];

  // Only lane 0 carries implemented CTRL bits
  assign ctrl_bus = byteen[0] ? wdata[3:0] : ctrl_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    pend_d   = pend_q;
    ctrl_fsm = ctrl_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StLoad;
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!en) begin
          state_d = StIdle;
        end else if (count_q == 32'd0) begin
          state_d = StInt;
          pend_d  = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      StInt: begin
        if (mode == ModeReload) begin
          pend_d  = 1'b0;
          state_d = StLoad;
        end else begin
          ctrl_fsm[CtrlEnBit] = 1'b0;
          state_d             = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A bus write to CTRL overrides the FSM's EN clear and drops the pending flag
    ctrl_d = ctrl_wr ? ctrl_bus : ctrl_fsm;
    if (ctrl_wr) pend_d = 1'b0;

    preset_d = preset_wr ? merge_bytes(preset_q, wdata, byteen) : preset_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ctrl_q   <= 4'b0;
      preset_q <= 32'b0;
      count_q  <= 32'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    rdata = 32'b0;
    if (sel) begin
      case (off)
        OffCtrl:   rdata = {28'b0, ctrl_q};
        OffPreset: rdata = preset_q;
        OffCount:  rdata = count_q;
        default:   rdata = 32'b0;
      endcase
    end
  end

  assign irq = pend_q & im;

endmodule

// File: tb/tb_timer_device.sv
// Directed self-checking bench for timer_device.
module tb_timer_device;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;
  localparam logic [31:0] A_OUT    = 32'h0000_7F10;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int vectors;
  int miscompares;

  timer_device #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle bus write; returns 1 unit after the edge that commits it
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr   = a;
    wdata  = d;
    byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'b0000;
    addr   = 32'h0;
    wdata  = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
    addr = 32'h0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    addr   = 32'h0;
    byteen = 4'b0;
    wdata  = 32'h0;

    // Reset state
    tick(2);
    rd(A_CTRL, "rst_ctrl", 32'h0);
    rd(A_PRESET, "rst_preset", 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick(1);
    rd(A_COUNT, "rst_count", 32'h0);
    rd(32'h0, "rst_unsel", 32'h0);

    // One-shot: PRESET=5, irq after E8 and held
    wr(A_PRESET, 32'd5, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);           // E0
    chk("os_irq_e0", {31'b0, irq}, 32'h0);
    tick(2);
    rd(A_COUNT, "os_count_e2", 32'd5);
    tick(3);
    rd(A_COUNT, "os_count_e5", 32'd2);
    tick(2);
    rd(A_COUNT, "os_count_e7", 32'd0);
    chk("os_irq_e7", {31'b0, irq}, 32'h0);
    tick(1);
    chk("os_irq_e8", {31'b0, irq}, 32'h1);
    rd(A_CTRL, "os_ctrl_e8", 32'h9);
    tick(1);
    rd(A_CTRL, "os_ctrl_e9", 32'h8);
    tick(3);
    chk("os_irq_held", {31'b0, irq}, 32'h1);
    wr(A_CTRL, 32'h8, 4'hF);
    chk("os_irq_cleared", {31'b0, irq}, 32'h0);
    rd(A_CTRL, "os_ctrl_after", 32'h8);

    // Auto-reload: PRESET=3, period 6, one-cycle pulses
    wr(A_PRESET, 32'd3, 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);           // E0
    tick(2);
    rd(A_COUNT, "ar_count_e2", 32'd3);
    for (int k = 3; k <= 26; k++) begin
      int ph;
      logic [31:0] exp_cnt;
      tick(1);
      ph = (k - 2) % 6;
      exp_cnt = (ph <= 3) ? 32'(3 - ph) : 32'd0;
      rd(A_COUNT, "ar_count", exp_cnt);
      chk("ar_irq", {31'b0, irq}, (k >= 6 && (k - 6) % 6 == 0) ? 32'h1 : 32'h0);
    end
    // E26 reloaded to 3; E27 decrements while EN is cleared; E28 idles
    wr(A_CTRL, 32'h0, 4'b0001);
    tick(3);
    rd(A_COUNT, "ar_count_frozen", 32'd2);
    chk("ar_irq_stopped", {31'b0, irq}, 32'h0);

    // Masked: PRESET=2, CTRL=0x1, pend sets but irq stays 0
    wr(A_PRESET, 32'd2, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk("mask_irq", {31'b0, irq}, 32'h0);
    end
    rd(A_CTRL, "mask_ctrl_en_cleared", 32'h0);
    wr(A_CTRL, 32'h8, 4'hF);           // clears pend, then unmasks
    chk("mask_pend_cleared", {31'b0, irq}, 32'h0);

    // Byte enables and read-only/reserved writes
    wr(A_PRESET, 32'h0, 4'hF);
    wr(A_PRESET, 32'hAABB_CCDD, 4'b0010);
    rd(A_PRESET, "be_lane1", 32'h0000_CC00);
    wr(A_PRESET, 32'h1122_3344, 4'b1001);
    rd(A_PRESET, "be_lane03", 32'h1100_CC44);
    wr(A_COUNT, 32'hDEAD_BEEF, 4'hF);
    rd(A_COUNT, "count_ro", 32'h0);
    wr(A_RSVD, 32'hFFFF_FFFF, 4'hF);
    rd(A_RSVD, "rsvd_zero", 32'h0);
    rd(A_PRESET, "rsvd_no_alias", 32'h1100_CC44);
    wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
    rd(A_CTRL, "ctrl_upper_zero", 32'h8);

    // PRESET=0: irq after 3 edges
    wr(A_PRESET, 32'h0, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);           // E0
    tick(2);
    chk("p0_irq_e2", {31'b0, irq}, 32'h0);
    tick(1);
    chk("p0_irq_e3", {31'b0, irq}, 32'h1);
    wr(A_CTRL, 32'h0, 4'hF);
    chk("p0_irq_cleared", {31'b0, irq}, 32'h0);

    // Clear EN during CNT: COUNT freezes, no irq
    wr(A_PRESET, 32'd10, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);           // E0
    tick(2);
    rd(A_COUNT, "ce_count_e2", 32'd10);
    tick(2);
    rd(A_COUNT, "ce_count_e4", 32'd8);
    wr(A_CTRL, 32'h8, 4'hF);           // E5: last decrement
    rd(A_COUNT, "ce_count_e5", 32'd7);
    tick(15);
    rd(A_COUNT, "ce_count_frozen", 32'd7);
    chk("ce_irq", {31'b0, irq}, 32'h0);

    // Out-of-window access
    wr(A_OUT, 32'hFFFF_FFFF, 4'hF);
    rd(A_OUT, "oow_rdata", 32'h0);
    rd(A_CTRL, "oow_ctrl", 32'h8);
    rd(A_PRESET, "oow_preset", 32'd10);
    tick(1);
    rd(A_COUNT, "oow_count", 32'd7);

    // Reset mid-count
    wr(A_PRESET, 32'd100, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);           // E0
    tick(19);
    rd(A_COUNT, "mr_count_e19", 32'd83);
    tick(1);
    reset = 1'b1;
    rd(A_COUNT, "mr_count", 32'h0);
    rd(A_CTRL, "mr_ctrl", 32'h0);
    chk("mr_irq", {31'b0, irq}, 32'h0);
    rd(A_PRESET, "mr_preset", 32'h0);
    reset = 1'b0;
    tick(5);
    rd(A_COUNT, "mr_idle_count", 32'h0);
    rd(A_CTRL, "mr_idle_ctrl", 32'h0);
    chk("mr_idle_irq", {31'b0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
